// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Produces the load enables and bubble flushes for PC, IF/ID, ID/EX,
// EX/MEM and MEM/WB. It handles three cases:
//   - load-use hazards between EX and ID
//   - taken branches resolved in MEM
//   - multi-cycle data-memory accesses, with timeout supervision
// Optional build macro PIPE_STALL_CNT_EN enables the stall_cycles counter.
// When the macro is undefined, stall_cycles is tied to zero.
module pipe_hazard_ctrl #(
  parameter int WAIT_TIMEOUT = 64,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_write_reg,
  input  logic             mem_branch_taken,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             pc_sel_branch,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WCNT_W = $clog2(WAIT_TIMEOUT);

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                mem_err_q, mem_err_d;

  logic timeout;
  logic freeze;
  logic lu;

  // A MEM access may occupy MEM for at most WAIT_TIMEOUT cycles. The last of
  // these cycles is released unconditionally and is treated like a completion.
  assign timeout = (state_q == ST_MEM_WAIT) &&
                   (wait_cnt_q == WCNT_W'(WAIT_TIMEOUT - 1));
  assign freeze  = mem_access && !dmem_ready && !timeout;

  // A load in EX writing a register that ID reads. Register $0 never creates a hazard.
  assign lu = ex_mem_read && (ex_write_reg != 5'd0) &&
              ((ex_write_reg == id_rs) || (id_uses_rt && (ex_write_reg == id_rt)));

  // State register: async reset returns to RUN and clears the error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  // Next-state logic: enter MEM_WAIT on the first frozen cycle.
  // Count the wait, then leave on ready or on timeout.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q | timeout;
    unique case (state_q)
      ST_RUN: begin
        if (freeze) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WCNT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (freeze) begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end else begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Mealy outputs in priority order: memory freeze, taken branch, load-use, normal flow.
  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    pc_sel_branch = 1'b0;
    if (freeze) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (mem_branch_taken) begin
      // The three younger slots are wrong-path, including any load-use victim in ID.
      pc_sel_branch = 1'b1;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      ex_mem_flush  = 1'b1;
    end else if (lu) begin
      // Hold PC and IF/ID for one cycle and send a bubble into EX.
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  assign mem_err = mem_err_q;

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Next value of the stall counter: count cycles with the PC held, saturating at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Stall counter register, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed test of pipe_hazard_ctrl with WAIT_TIMEOUT=8.
// Inputs are driven on the falling edge. Outputs are checked 1 ns later,
// well away from the rising edge.
module tb_pipe_hazard_ctrl;

  localparam int WT    = 8;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic [4:0]       id_rs, id_rt, ex_write_reg;
  logic             id_uses_rt, ex_mem_read, mem_branch_taken, mem_access, dmem_ready;
  logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic             if_id_flush, id_ex_flush, ex_mem_flush, pc_sel_branch, mem_err;
  logic [CNT_W-1:0] stall_cycles;

  int n_assert = 0;
  int n_fail   = 0;

  pipe_hazard_ctrl #(.WAIT_TIMEOUT(WT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_write_reg(ex_write_reg),
    .mem_branch_taken(mem_branch_taken), .mem_access(mem_access), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .pc_sel_branch(pc_sel_branch), .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected stall count: the counter exists only in the PIPE_STALL_CNT_EN build.
  function automatic logic [31:0] sc(input int n);
`ifdef PIPE_STALL_CNT_EN
    return 32'(n);
`else
    return 32'(n - n);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // en = {pc,if_id,id_ex,ex_mem,mem_wb}, fl = {if_id,id_ex,ex_mem}
  task automatic chk_out(input string tag, input logic [4:0] en, input logic [2:0] fl,
                         input logic sel);
    chk({tag, "/en"}, 32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 32'(en));
    chk({tag, "/fl"}, 32'({if_id_flush, id_ex_flush, ex_mem_flush}), 32'(fl));
    chk({tag, "/sel"}, 32'(pc_sel_branch), 32'(sel));
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
    ex_write_reg = 5'd0; mem_branch_taken = 1'b0; mem_access = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic set_lu();
    ex_mem_read = 1'b1; ex_write_reg = 5'd8; id_rs = 5'd8;
  endtask

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    @(negedge clk); #1;
    $display("step reset: idle inputs");
    chk_out("rst_idle", 5'h1F, 3'b000, 1'b0);
    chk("rst_stall", 32'(stall_cycles), 32'd0);
    chk("rst_err", 32'(mem_err), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'd0);
    // Outputs follow RUN with live inputs even while reset is held.
    mem_access = 1'b1;
    #1;
    $display("step reset: freeze inputs during reset");
    chk_out("rst_freeze", 5'h00, 3'b000, 1'b0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;

    // Load-use: one bubble, then the load has moved to MEM.
    @(negedge clk);
    set_lu();
    #1;
    $display("step lu: load r8 in EX, ID reads r8");
    chk_out("lu", 5'b00111, 3'b010, 1'b0);
    @(negedge clk);
    idle(); mem_access = 1'b1; dmem_ready = 1'b1;
    #1;
    $display("step lu_next: load in MEM, ready at once");
    chk_out("lu_next", 5'h1F, 3'b000, 1'b0);
    chk("lu_stall", 32'(stall_cycles), sc(1));
    @(posedge clk); #1;
    chk("ready0_state", 32'(dut.state_q), 32'd0);

    // No false hazards.
    @(negedge clk);
    idle(); ex_mem_read = 1'b1; ex_write_reg = 5'd0; id_rs = 5'd0;
    #1;
    $display("step nohaz_r0: load writes r0");
    chk_out("nohaz_r0", 5'h1F, 3'b000, 1'b0);
    @(negedge clk);
    idle(); ex_mem_read = 1'b1; ex_write_reg = 5'd9; id_rt = 5'd9; id_rs = 5'd3;
    #1;
    $display("step nohaz_rt: rt match but rt unused");
    chk_out("nohaz_rt", 5'h1F, 3'b000, 1'b0);
    @(negedge clk);
    id_uses_rt = 1'b1;
    #1;
    $display("step lu_rt: rt match, rt used");
    chk_out("lu_rt", 5'b00111, 3'b010, 1'b0);

    // Branch and load-use together: the branch wins.
    @(negedge clk);
    idle(); set_lu(); mem_branch_taken = 1'b1;
    #1;
    $display("step br_lu: branch taken with load-use");
    chk_out("br_lu", 5'h1F, 3'b111, 1'b1);
    chk("br_lu_stall", 32'(stall_cycles), sc(2));

    // Memory wait: ready first seen in cycle 3.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      idle(); mem_access = 1'b1;
      if (c == 1) mem_branch_taken = 1'b1;
      #1;
      $display("step mwait cycle %0d", c);
      chk_out($sformatf("mwait%0d", c), 5'h00, 3'b000, 1'b0);
      chk($sformatf("mwait%0d_state", c), 32'(dut.state_q), (c == 0) ? 32'd0 : 32'd1);
    end
    @(negedge clk);
    dmem_ready = 1'b1;
    #1;
    $display("step mwait release");
    chk_out("mwait_rel", 5'h1F, 3'b000, 1'b0);
    chk("mwait_stall", 32'(stall_cycles), sc(5));
    @(posedge clk); #1;
    chk("mwait_state", 32'(dut.state_q), 32'd0);
    chk("mwait_err", 32'(mem_err), 32'd0);

    // Timeout: ready never comes. Cycles 0..WT-2 freeze; cycle WT-1 is released.
    for (int c = 0; c < WT - 1; c++) begin
      @(negedge clk);
      idle(); mem_access = 1'b1;
      #1;
      $display("step tmo cycle %0d", c);
      chk_out($sformatf("tmo%0d", c), 5'h00, 3'b000, 1'b0);
    end
    @(negedge clk);
    set_lu();
    #1;
    $display("step tmo release with load-use");
    chk_out("tmo_rel", 5'b00111, 3'b010, 1'b0);
    chk("tmo_err_pre", 32'(mem_err), 32'd0);
    chk("tmo_stall", 32'(stall_cycles), sc(12));
    @(posedge clk); #1;
    chk("tmo_err", 32'(mem_err), 32'd1);
    chk("tmo_state", 32'(dut.state_q), 32'd0);
    @(negedge clk);
    idle(); mem_access = 1'b1; dmem_ready = 1'b1; mem_branch_taken = 1'b1;
    #1;
    $display("step after timeout traffic");
    chk_out("post_tmo", 5'h1F, 3'b111, 1'b1);
    chk("post_tmo_stall", 32'(stall_cycles), sc(13));
    @(negedge clk);
    idle();
    #1;
    chk("err_sticky", 32'(mem_err), 32'd1);

    // Reset in the middle of a wait.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      idle(); mem_access = 1'b1;
    end
    #1;
    chk("mid_state", 32'(dut.state_q), 32'd1);
    rst_n = 1'b0;
    #1;
    $display("step reset mid-wait");
    chk("rstw_state", 32'(dut.state_q), 32'd0);
    chk("rstw_stall", 32'(stall_cycles), 32'd0);
    chk("rstw_err", 32'(mem_err), 32'd0);
    chk_out("rstw_out", 5'h00, 3'b000, 1'b0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;

    // Fresh full timeout after reset: wait counter must have been cleared.
    for (int c = 0; c < WT - 1; c++) begin
      @(negedge clk);
      idle(); mem_access = 1'b1;
      #1;
      $display("step tmo2 cycle %0d", c);
      chk_out($sformatf("tmo2_%0d", c), 5'h00, 3'b000, 1'b0);
    end
    @(negedge clk);
    #1;
    $display("step tmo2 release");
    chk_out("tmo2_rel", 5'h1F, 3'b000, 1'b0);
    chk("tmo2_stall", 32'(stall_cycles), sc(7));
    @(posedge clk); #1;
    chk("tmo2_err", 32'(mem_err), 32'd1);
    @(negedge clk);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
